// File: rtl/tinymips_pkg.sv
// Shared encodings for the tinymips controllers: FSM states, opcodes,
// funct fields, ALU control codes and the ALUOp selector.
package tinymips_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11,
    S_TRAP    = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

endpackage

// File: rtl/alu_decoder.sv
// ALU control decode: ALUOp picks add/sub directly or defers to Funct.
// FunctValid flags the R-type functs this core implements, independent of ALUOp.
module alu_decoder
  import tinymips_pkg::*;
(
  input  logic [1:0] i_aluop,
  input  logic [5:0] i_funct,
  output logic [2:0] o_alu_control,
  output logic       o_funct_valid
);

  logic [2:0] w_fn_ctl;

  // Map the R-type funct field to an ALU code and flag supported encodings
  always_comb begin
    w_fn_ctl      = ALU_ADD;
    o_funct_valid = 1'b0;
    case (i_funct)
      FN_ADD: begin w_fn_ctl = ALU_ADD; o_funct_valid = 1'b1; end
      FN_SUB: begin w_fn_ctl = ALU_SUB; o_funct_valid = 1'b1; end
      FN_AND: begin w_fn_ctl = ALU_AND; o_funct_valid = 1'b1; end
      FN_OR:  begin w_fn_ctl = ALU_OR;  o_funct_valid = 1'b1; end
      FN_SLT: begin w_fn_ctl = ALU_SLT; o_funct_valid = 1'b1; end
      default: ;
    endcase
  end

  // Select the final ALU operation from ALUOp
  always_comb begin
    case (i_aluop)
      ALUOP_SUB:   o_alu_control = ALU_SUB;
      ALUOP_FUNCT: o_alu_control = w_fn_ctl;
      default:     o_alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Moore controller for the multicycle tinymips datapath. Outputs decode from
// the state register; all write enables are held off while reset is high.
module mips_multicycle_ctrl
  import tinymips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OP,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       Mem2Reg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic [2:0] ALUControl,
  output logic       Illegal
);

  state_t     r_state;
  state_t     w_next;
  logic [1:0] w_aluop;
  logic       w_funct_valid;
  logic       w_memwrite, w_irwrite, w_regwrite, w_pcwrite, w_branch, w_illegal;

  alu_decoder u_alu_dec (
    .i_aluop       (w_aluop),
    .i_funct       (Funct),
    .o_alu_control (ALUControl),
    .o_funct_valid (w_funct_valid)
  );

  // State register; reset returns to FETCH from any point in an instruction
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  // Next-state: opcode is only consulted in DECODE and MEMADR
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH: w_next = S_DECODE;
      S_DECODE: begin
        case (OP)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = w_funct_valid ? S_EXECUTE : S_TRAP;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JUMP;
          default:      w_next = S_TRAP;
        endcase
      end
      S_MEMADR:  w_next = (OP == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   w_next = S_MEMWB;
      S_EXECUTE: w_next = S_ALUWB;
      S_ADDIEX:  w_next = S_ADDIWB;
      default:   w_next = S_FETCH;
    endcase
  end

  // Per-state datapath controls; anything not set for a state stays 0
  always_comb begin
    IorD       = 1'b0;
    RegDst     = 1'b0;
    Mem2Reg    = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    PCSrc      = 2'b00;
    w_aluop    = ALUOP_ADD;
    w_memwrite = 1'b0;
    w_irwrite  = 1'b0;
    w_regwrite = 1'b0;
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    w_illegal  = 1'b0;
    case (r_state)
      S_FETCH: begin
        ALUSrcB   = 2'b01;
        w_irwrite = 1'b1;
        w_pcwrite = 1'b1;
      end
      S_DECODE:  ALUSrcB = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD:   IorD = 1'b1;
      S_MEMWB: begin
        Mem2Reg    = 1'b1;
        w_regwrite = 1'b1;
      end
      S_MEMWR: begin
        IorD       = 1'b1;
        w_memwrite = 1'b1;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        w_aluop = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        RegDst     = 1'b1;
        w_regwrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        w_aluop  = ALUOP_SUB;
        PCSrc    = 2'b01;
        w_branch = 1'b1;
      end
      S_ADDIWB:  w_regwrite = 1'b1;
      S_JUMP: begin
        PCSrc     = 2'b10;
        w_pcwrite = 1'b1;
      end
      S_TRAP:    w_illegal = 1'b1;
      default: ;
    endcase
  end

  // Reset masks every enable so an interrupted instruction cannot commit
  assign MemWrite = w_memwrite & ~reset;
  assign IRWrite  = w_irwrite  & ~reset;
  assign RegWrite = w_regwrite & ~reset;
  assign Illegal  = w_illegal  & ~reset;
  assign PCEn     = (w_pcwrite | (w_branch & Zero)) & ~reset;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized bench for the multicycle controller. The reference model
// describes each instruction as a list of per-cycle control expectations.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] OP, Funct;
  logic       Zero;
  logic       IorD, MemWrite, IRWrite, RegDst, Mem2Reg, RegWrite, ALUSrcA, PCEn, Illegal;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALUControl;

  typedef struct packed {
    logic       iord, memwrite, irwrite, regdst, mem2reg, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic       pcen;
    logic [2:0] aluctl;
    logic       illegal;
  } ctl_t;

  int n_checks = 0;
  int n_errors = 0;

  mips_multicycle_ctrl dut (
    .clk(clk), .reset(reset), .OP(OP), .Funct(Funct), .Zero(Zero),
    .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
    .Mem2Reg(Mem2Reg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .PCSrc(PCSrc), .PCEn(PCEn), .ALUControl(ALUControl), .Illegal(Illegal)
  );

  always #5 clk = ~clk;

  logic [15:0] got;
  logic [4:0]  gated;
  assign got   = {IorD, MemWrite, IRWrite, RegDst, Mem2Reg, RegWrite, ALUSrcA,
                  ALUSrcB, PCSrc, PCEn, ALUControl, Illegal};
  assign gated = {MemWrite, IRWrite, RegWrite, PCEn, Illegal};

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  // R-type funct -> ALU code, plus whether the funct is supported
  function automatic logic [3:0] fn_info(input logic [5:0] fn);
    case (fn)
      6'd32:   return {1'b1, 3'b010};
      6'd34:   return {1'b1, 3'b110};
      6'd36:   return {1'b1, 3'b000};
      6'd37:   return {1'b1, 3'b001};
      6'd42:   return {1'b1, 3'b111};
      default: return 4'b0000;
    endcase
  endfunction

  // 0 lw, 1 sw, 2 rtype, 3 beq, 4 addi, 5 j, 6 trap
  function automatic int kind_of(input logic [5:0] op, input logic [5:0] fn);
    logic [3:0] fi;
    fi = fn_info(fn);
    case (op)
      6'd35:   return 0;
      6'd43:   return 1;
      6'd0:    return fi[3] ? 2 : 6;
      6'd4:    return 3;
      6'd8:    return 4;
      6'd2:    return 5;
      default: return 6;
    endcase
  endfunction

  function automatic int lat_of(input int kind);
    case (kind)
      0: return 5;
      1, 2, 4: return 4;
      default: return 3;
    endcase
  endfunction

  function automatic ctl_t expect_ctl(input logic [5:0] op, input logic [5:0] fn,
                                      input int k, input logic z);
    ctl_t c;
    logic [3:0] fi;
    int kind;
    fi = fn_info(fn);
    kind = kind_of(op, fn);
    c = '0;
    c.aluctl = 3'b010;
    if (k == 0) begin
      c.alusrcb = 2'b01; c.irwrite = 1'b1; c.pcen = 1'b1;
    end else if (k == 1) begin
      c.alusrcb = 2'b11;
    end else begin
      case (kind)
        0: case (k)
             2: begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
             3: c.iord = 1'b1;
             default: begin c.mem2reg = 1'b1; c.regwrite = 1'b1; end
           endcase
        1: if (k == 2) begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
           else begin c.iord = 1'b1; c.memwrite = 1'b1; end
        2: if (k == 2) begin c.alusrca = 1'b1; c.aluctl = fi[2:0]; end
           else begin c.regdst = 1'b1; c.regwrite = 1'b1; end
        3: begin c.alusrca = 1'b1; c.aluctl = 3'b110; c.pcsrc = 2'b01; c.pcen = z; end
        4: if (k == 2) begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
           else c.regwrite = 1'b1;
        5: begin c.pcsrc = 2'b10; c.pcen = 1'b1; end
        default: c.illegal = 1'b1;
      endcase
    end
    return c;
  endfunction

  // Entered at posedge+1 with the DUT in FETCH; leaves it back in FETCH.
  // zsel<0 randomizes Zero; abort_at>=0 asserts reset during that cycle.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input int zsel, input int abort_at, input string name);
    int lat;
    lat = lat_of(kind_of(op, fn));
    for (int k = 0; k < lat; k++) begin
      if (k == 0) begin OP = 6'($urandom); Funct = 6'($urandom); end
      else begin OP = op; Funct = fn; end
      Zero = (zsel < 0) ? 1'($urandom_range(0, 1)) : zsel[0];
      if (k == abort_at) begin
        reset = 1'b1;
        #1;
        chk($sformatf("%s rst c%0d", name, k + 1), {11'd0, gated}, 16'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        return;
      end
      #1;
      chk($sformatf("%s c%0d", name, k + 1), got, expect_ctl(op, fn, k, Zero));
      @(posedge clk); #1;
    end
  endtask

  logic [5:0] legal_fn [5] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42};

  initial begin
    reset = 1'b1; OP = 6'b100011; Funct = 6'd0; Zero = 1'b0;
    #2 chk("rst0", {11'd0, gated}, 16'd0);
    @(posedge clk); #1 chk("rst1", {11'd0, gated}, 16'd0);
    @(posedge clk); #1 chk("rst2", {11'd0, gated}, 16'd0);
    reset = 1'b0;

    run_instr(6'b100011, 6'd0,  -1, -1, "lw");
    run_instr(6'b000000, 6'd42, -1, -1, "slt");
    run_instr(6'b000100, 6'd0,   1, -1, "beq_t");
    run_instr(6'b000100, 6'd0,   0, -1, "beq_nt");
    run_instr(6'b111111, 6'd0,  -1, -1, "ill_op");
    run_instr(6'b000000, 6'd0,  -1, -1, "ill_fn");
    run_instr(6'b101011, 6'd0,  -1,  3, "sw_abort");
    run_instr(6'b101011, 6'd0,  -1, -1, "sw");
    run_instr(6'b001000, 6'd0,  -1, -1, "addi");
    run_instr(6'b000010, 6'd0,  -1, -1, "j");

    for (int i = 0; i < 300; i++) begin
      logic [5:0] op, fn;
      int sel, ab;
      sel = $urandom_range(0, 9);
      fn = legal_fn[$urandom_range(0, 4)];
      case (sel)
        0: op = 6'b100011;
        1: op = 6'b101011;
        2, 3: op = 6'b000000;
        4: op = 6'b000100;
        5: op = 6'b001000;
        6: op = 6'b000010;
        7: begin op = 6'b000000; fn = 6'($urandom); end
        default: op = 6'($urandom);
      endcase
      ab = ($urandom_range(0, 15) == 0) ? $urandom_range(0, lat_of(kind_of(op, fn)) - 1) : -1;
      run_instr(op, fn, -1, ab, $sformatf("r%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule
